// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame width and default bit period.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int NUMBITS          = 8;
  localparam int CLKS_PER_BIT_DEF = 320;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter for the transmitter.
// Produces a tick on the last enabled cycle of each serial symbol.
module uart_tx_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick
);

  localparam int               CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  assign o_tick = i_en && i_run && (r_count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && i_run) begin
      r_count <= o_tick ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_out.sv
// 8N1 UART transmitter: LSB first, idle-high line, busy/done handshake,
// global clock enable that freezes the whole block.
module uart_out
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       MHz10,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] dataIn,
  output logic       serOut,
  output logic       busy,
  output logic       done
);

  uart_state_e        r_state, w_state_nxt;
  logic [NUMBITS-1:0] r_shift, w_shift_nxt;
  logic [2:0]         r_idx,   w_idx_nxt;
  logic               r_ser,   w_ser_nxt;
  logic               r_busy,  w_busy_nxt;
  logic               r_done,  w_done_nxt;
  logic               w_accept;
  logic               w_tick;

  assign w_accept = en && (r_state == IDLE) && start;

  uart_tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (MHz10),
    .rst    (rst),
    .i_en   (en),
    .i_clear(w_accept),
    .i_run  (r_busy),
    .o_tick (w_tick)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_ser_nxt   = r_ser;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    if (en) begin
      w_done_nxt = 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            w_shift_nxt = dataIn;
            w_state_nxt = START;
            w_ser_nxt   = 1'b0;
            w_busy_nxt  = 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            w_state_nxt = DATA;
            w_ser_nxt   = r_shift[0];
            w_idx_nxt   = '0;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_idx == 3'(NUMBITS - 1)) begin
              w_state_nxt = STOP;
              w_ser_nxt   = 1'b1;
            end else begin
              // Next bit is taken from the pre-shift register, i.e. bit 1.
              w_shift_nxt = r_shift >> 1;
              w_ser_nxt   = r_shift[1];
              w_idx_nxt   = r_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge MHz10 or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_ser   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_ser   <= w_ser_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign serOut = r_ser;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_uart_out.sv
// Directed bench for uart_out: frame table with per-cycle waveform checks,
// back-to-back, mid-frame reset and a fast loopback against a sampling receiver.
module tb_uart_out;

  localparam int CPB    = 320;
  localparam int CPB_LB = 4;

  logic       clk = 1'b0;
  logic       rst, en, start;
  logic [7:0] data_in;
  logic       ser, busy, done;
  logic       en1, start1;
  logic [7:0] data1;
  logic       ser1, busy1, done1;

  always #50 clk = ~clk;

  uart_out #(.CLKS_PER_BIT(CPB)) dut (
    .MHz10(clk), .rst(rst), .en(en), .start(start), .dataIn(data_in),
    .serOut(ser), .busy(busy), .done(done)
  );

  uart_out #(.CLKS_PER_BIT(CPB_LB)) dut_lb (
    .MHz10(clk), .rst(rst), .en(en1), .start(start1), .dataIn(data1),
    .serOut(ser1), .busy(busy1), .done(done1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] syms;     // bit k = level of symbol k (start first)
    bit         poke;     // restart attempt with dataIn=FF at cycle 1000
    int         off_sym;  // symbol during which en drops
    int         off_len;  // number of disabled cycles
  } vec_t;

  vec_t vecs[5];

  // Entered at the first negedge after acceptance (cycle 0); returns at the done cycle.
  task automatic run_frame(input string name, input logic [9:0] syms, input bit poke,
                           input int off_sym, input int off_len);
    int   total, wave_err, busy_err, done_at, pos, w;
    logic exp_bit;
    total    = 10 * CPB + off_len;
    wave_err = 0;
    busy_err = 0;
    done_at  = -1;
    for (int n = 0; n <= total + 50; n++) begin
      exp_bit = 1'b1;
      pos     = n;
      for (int s = 0; s < 10; s++) begin
        w = CPB + ((s == off_sym) ? off_len : 0);
        if (pos < w) begin
          exp_bit = syms[s];
          break;
        end
        pos -= w;
      end
      if (ser !== exp_bit) wave_err++;
      if (done === 1'b1) begin
        if (busy !== 1'b0) busy_err++;
        done_at = n;
        break;
      end
      if (busy !== 1'b1) busy_err++;
      if (poke && n == 1000) begin
        start   = 1'b1;
        data_in = 8'hFF;
      end
      if (poke && n == 1001) start = 1'b0;
      if (off_len > 0 && n == off_sym * CPB + 100) en = 1'b0;
      if (off_len > 0 && n == off_sym * CPB + 100 + off_len) en = 1'b1;
      @(negedge clk);
    end
    check({name, "_done_at"}, done_at, total);
    check({name, "_wave_err"}, wave_err, 0);
    check({name, "_busy_err"}, busy_err, 0);
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    check(name, {29'd0, done, busy, ser}, 32'b001);
  endtask

  initial begin
    int         bad;
    int         cur;
    logic [7:0] b, rx;
    logic       stop_bit, timeout;

    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0, 0, 0};
    vecs[1] = '{8'h3C, 10'b1001111000, 1'b1, 0, 0};
    vecs[2] = '{8'h55, 10'b1010101010, 1'b0, 4, 50};
    vecs[3] = '{8'h80, 10'b1100000000, 1'b0, 0, 0};
    vecs[4] = '{8'h01, 10'b1000000010, 1'b0, 0, 0};

    rst = 1'b1; en = 1'b1; start = 1'b0; data_in = 8'h00;
    en1 = 1'b1; start1 = 1'b0; data1 = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, ser1, done, busy, ser}, 32'b1001);
    rst = 1'b0;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ser !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      start   = 1'b1;
      data_in = vecs[i].data;
      @(negedge clk);
      start   = 1'b0;
      data_in = ~vecs[i].data;
      run_frame($sformatf("frame_%02h", vecs[i].data), vecs[i].syms, vecs[i].poke,
                vecs[i].off_sym, vecs[i].off_len);
      expect_idle($sformatf("frame_%02h_after", vecs[i].data));
    end

    // Back-to-back: start held high across the done cycle.
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'h00;
    @(negedge clk);
    data_in = 8'hFF;
    run_frame("b2b_first", 10'b1000000000, 1'b0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    run_frame("b2b_second", 10'b1111111110, 1'b0, 0, 0);
    expect_idle("b2b_after");

    // Mid-frame reset aborts the frame; acceptance right after release.
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'h55;
    @(negedge clk);
    start = 1'b0;
    bad   = 0;
    repeat (1500) begin
      @(negedge clk);
      if (done !== 1'b0) bad++;
    end
    check("rst_pre_ser", {31'd0, ser}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_async", {30'd0, busy, ser}, 32'b01);
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) bad++;
    end
    check("rst_no_done", bad, 0);
    rst     = 1'b0;
    start   = 1'b1;
    data_in = 8'h01;
    @(negedge clk);
    start = 1'b0;
    run_frame("post_rst", 10'b1000000010, 1'b0, 0, 0);
    expect_idle("post_rst_after");

    // Loopback against a mid-bit sampling receiver on the fast instance.
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      @(negedge clk);
      start1 = 1'b1;
      data1  = b;
      @(negedge clk);
      start1  = 1'b0;
      timeout = 1'b0;
      cur     = 0;
      while (ser1 !== 1'b0 && cur < 10) begin
        @(negedge clk);
        cur++;
      end
      if (cur >= 10) timeout = 1'b1;
      cur = 0;
      rx  = 8'h00;
      for (int k = 1; k <= 8; k++) begin
        while (cur < k * CPB_LB + CPB_LB / 2) begin
          @(negedge clk);
          cur++;
        end
        rx[k-1] = ser1;
      end
      while (cur < 9 * CPB_LB + CPB_LB / 2) begin
        @(negedge clk);
        cur++;
      end
      stop_bit = ser1;
      while (done1 !== 1'b1 && cur < 12 * CPB_LB) begin
        @(negedge clk);
        cur++;
      end
      if (done1 !== 1'b1) timeout = 1'b1;
      check($sformatf("loopback_%0d", i), {22'd0, timeout, stop_bit, rx}, {22'd0, 1'b0, 1'b1, b});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
